// File: rtl/wb_trace_buffer_if.sv
// wb_trace_buffer_if: write-back debug capture bus plus show-ahead trace read port.
interface wb_trace_buffer_if;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [3:0]  rd_wen;
    logic [4:0]  rd_wnum;
    logic [31:0] rd_wdata;
    modport master (
        output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, rd_ready,
        input  rd_valid, rd_pc, rd_wen, rd_wnum, rd_wdata
    );
    modport slave (
        input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, rd_ready,
        output rd_valid, rd_pc, rd_wen, rd_wnum, rd_wdata
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: circular FIFO of register-file write-backs with overflow statistics.
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trace_en,
    input  logic               filter_zero,
    input  logic               clr,
    wb_trace_buffer_if.slave   bus,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               overflow,
    output logic [15:0]        drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [72:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          cap, pop, push, drop;
    assign cap  = trace_en & (|bus.debug_wb_rf_wen)
                & ~(filter_zero & (bus.debug_wb_rf_wnum == 5'd0));
    assign full = count == CNT_W'(DEPTH);
    assign pop  = bus.rd_valid & bus.rd_ready;
    // A pop frees the slot in the same cycle, so a full buffer still accepts.
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;
    assign bus.rd_valid = count != '0;
    assign {bus.rd_pc, bus.rd_wen, bus.rd_wnum, bus.rd_wdata} = mem[rp];
    always_ff @(posedge clk)
        if (push) mem[wp] <= {bus.debug_wb_pc, bus.debug_wb_rf_wen, bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata};
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count    <= count + CNT_W'(push) - CNT_W'(pop);
            overflow <= overflow | drop;
            drop_cnt <= drop_cnt + 16'(drop && drop_cnt != 16'hFFFF);
        end
    end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: scoreboard bench; expected entries queue on capture, compare on pop.
module tb_wb_trace_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trace_en = 1'b1, filter_zero = 1'b0, clr = 1'b0;
    logic [4:0]  count;
    logic        full, overflow;
    logic [15:0] drop_cnt;
    int          n_vec = 0, n_err = 0;
    logic [72:0] sb [$];
    int          m_drop = 0;
    logic        m_ovf = 1'b0;
    int          max_cnt;
    wb_trace_buffer_if bus ();
    wb_trace_buffer #(.DEPTH(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en), .filter_zero(filter_zero), .clr(clr),
        .bus(bus), .count(count), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] pc, input logic [3:0] wen, input logic [4:0] wnum, input logic [31:0] wdata);
        bus.debug_wb_pc       = pc;
        bus.debug_wb_rf_wen   = wen;
        bus.debug_wb_rf_wnum  = wnum;
        bus.debug_wb_rf_wdata = wdata;
    endtask

    // Compare outputs on the falling edge, then advance the model by one cycle.
    task automatic step();
        logic cap, pop, was_full;
        @(negedge clk);
        check("rd_valid", bus.rd_valid, sb.size() != 0);
        check("count", count, sb.size());
        check("full", full, sb.size() == 16);
        check("overflow", overflow, m_ovf);
        check("drop_cnt", drop_cnt, m_drop);
        if (sb.size() != 0)
            check("head", {bus.rd_pc, bus.rd_wen, bus.rd_wnum, bus.rd_wdata}, sb[0]);
        if (int'(count) > max_cnt) max_cnt = int'(count);
        cap = trace_en && (bus.debug_wb_rf_wen != 4'd0) && !(filter_zero && bus.debug_wb_rf_wnum == 5'd0);
        pop = sb.size() != 0 && bus.rd_ready;
        was_full = sb.size() == 16;
        if (clr) begin
            sb.delete();
            m_drop = 0;
            m_ovf = 1'b0;
        end else begin
            if (pop) void'(sb.pop_front());
            if (cap && was_full && !pop) begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end else if (cap)
                sb.push_back({bus.debug_wb_pc, bus.debug_wb_rf_wen, bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr(32'h0, 4'h0, 5'd0, 32'h0);
    endtask

    initial begin
        idle();
        bus.rd_ready = 1'b0;
        #3;
        check("rst_count", count, 0);
        check("rst_valid", bus.rd_valid, 0);
        check("rst_drop", drop_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // single capture
        wr(32'hBFC00000, 4'hF, 5'd2, 32'h12345678);
        step();
        idle();
        step();
        check("single_fields", {bus.rd_pc, bus.rd_wen, bus.rd_wnum, bus.rd_wdata},
              {32'hBFC00000, 4'hF, 5'd2, 32'h12345678});
        check("single_count", count, 1);
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        step();
        // filtering
        wr(32'h100, 4'h0, 5'd3, 32'h1);
        step();
        filter_zero = 1'b1;
        wr(32'h104, 4'hF, 5'd0, 32'h2);
        step();
        filter_zero = 1'b0;
        step();
        idle();
        step();
        check("nofilter_count", count, 1);
        trace_en = 1'b0;
        wr(32'h108, 4'h3, 5'd7, 32'h3);
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        step();
        trace_en = 1'b1;
        // fill and overflow
        for (int i = 0; i < 20; i++) begin
            wr(32'h2000 + 32'(i * 4), 4'hF, 5'(i + 1), 32'(i));
            step();
        end
        idle();
        step();
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        check("fill_ovf", overflow, 1);
        check("fill_drop", drop_cnt, 4);
        // full with simultaneous push and pop
        bus.rd_ready = 1'b1;
        wr(32'h3000, 4'hF, 5'd9, 32'hAA);
        step();
        idle();
        check("fullpp_count", count, 16);
        check("fullpp_drop", drop_cnt, 4);
        for (int i = 0; i < 17; i++) step();
        // clear together with push and pop
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr(32'h4000, 4'h1, 5'd4, 32'(100 + i));
            step();
        end
        bus.rd_ready = 1'b1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        idle();
        check("clr_count", count, 0);
        check("clr_ovf", overflow, 0);
        step();
        // streaming and wrap-around
        max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            wr(32'h5000 + 32'(i * 4), 4'hF, 5'(i), 32'hC000 + 32'(i));
            step();
        end
        idle();
        step();
        step();
        check("stream_max", max_cnt, 1);
        check("stream_drop", drop_cnt, 0);
        // async reset mid-stream
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr(32'h6000, 4'hF, 5'd5, 32'(200 + i));
            step();
        end
        idle();
        check("pre_rst_count", count, 3);
        rst = 1'b1;
        #2;
        check("arst_count", count, 0);
        check("arst_valid", bus.rd_valid, 0);
        check("arst_full", full, 0);
        check("arst_ovf", overflow, 0);
        sb.delete();
        m_drop = 0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr(32'h7000, 4'h2, 5'd6, 32'hDEAD);
        step();
        idle();
        bus.rd_ready = 1'b1;
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
